// File: rtl/prt_dprx_vid_pkg.sv
// Shared types and defaults for the DP RX video FIFO read-side control.
package prt_dprx_vid_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClr   = 2'd1,
        StPrime = 2'd2,
        StRun   = 2'd3
    } rdctl_state_e;

    localparam int unsigned DefThres  = 8;
    localparam int unsigned DefClrCyc = 4;
    localparam int unsigned ClrCntW   = 4;

endpackage

// File: rtl/prt_dprx_vid_fifo_rdctl.sv
// Video-clock read scheduler: clears, primes and streams the video FIFO array,
// recovering from underrun by re-clearing and re-priming.
module prt_dprx_vid_fifo_rdctl
    import prt_dprx_vid_pkg::*;
#(
    parameter int unsigned P_LANES    = 4,
    parameter int unsigned P_SEGMENTS = 4,
    parameter int unsigned P_STRIPES  = 4,
    parameter int unsigned P_CLR_CYC  = DefClrCyc
) (
    input  logic                 VID_CLK_IN,
    input  logic                 VID_RST_IN,
    input  logic                 CFG_EN_IN,
    input  logic [5:0]           CFG_THRES_IN,
    input  logic [5:0]           FIFO_LVL_IN,
    input  logic                 REQ_IN,
    input  logic                 STA_CLR_IN,
    output logic                 FIFO_CLR_OUT,
    output logic [P_STRIPES-1:0] FIFO_RD_OUT [P_LANES][P_SEGMENTS],
    output logic                 RDY_OUT,
    output logic                 STA_URUN_OUT,
    output logic [7:0]           STA_URUN_CNT_OUT,
    output logic [1:0]           STA_STATE_OUT
);

    localparam logic [ClrCntW-1:0] ClrLoad = ClrCntW'(P_CLR_CYC - 1);

    rdctl_state_e       r_state;
    rdctl_state_e       w_state_nxt;
    logic [ClrCntW-1:0] r_clr_cnt;
    logic [ClrCntW-1:0] w_clr_cnt_nxt;
    logic               r_urun;
    logic               w_urun_nxt;
    logic [7:0]         r_urun_cnt;
    logic [7:0]         w_urun_cnt_nxt;
    logic [5:0]         w_thres_eff;
    logic               w_underrun;
    logic               w_rd;

    always_comb begin
        w_thres_eff = (CFG_THRES_IN == 6'd0) ? 6'd1 : CFG_THRES_IN;
        w_underrun  = (r_state == StRun) && REQ_IN && (FIFO_LVL_IN == 6'd0);
        w_rd        = (r_state == StRun) && REQ_IN && (FIFO_LVL_IN != 6'd0);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        unique case (r_state)
            StIdle: begin
                if (CFG_EN_IN) begin
                    w_state_nxt   = StClr;
                    w_clr_cnt_nxt = ClrLoad;
                end
            end
            StClr: begin
                if (r_clr_cnt == '0) begin
                    w_state_nxt = StPrime;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt - 1'b1;
                end
            end
            StPrime: begin
                if (FIFO_LVL_IN >= w_thres_eff) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_underrun) begin
                    w_state_nxt   = StClr;
                    w_clr_cnt_nxt = ClrLoad;
                end
            end
        endcase
        // Disable beats everything, including the underrun re-prime.
        if (!CFG_EN_IN) begin
            w_state_nxt = StIdle;
        end
    end

    always_comb begin
        w_urun_nxt     = r_urun;
        w_urun_cnt_nxt = r_urun_cnt;
        if (STA_CLR_IN) begin
            w_urun_nxt     = 1'b0;
            w_urun_cnt_nxt = 8'd0;
        end else if (w_underrun) begin
            w_urun_nxt = 1'b1;
            if (r_urun_cnt != 8'hFF) begin
                w_urun_cnt_nxt = r_urun_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge VID_CLK_IN or posedge VID_RST_IN) begin
        if (VID_RST_IN) begin
            r_state    <= StIdle;
            r_clr_cnt  <= '0;
            r_urun     <= 1'b0;
            r_urun_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_urun     <= w_urun_nxt;
            r_urun_cnt <= w_urun_cnt_nxt;
        end
    end

    always_comb begin
        FIFO_CLR_OUT     = (r_state == StIdle) || (r_state == StClr);
        RDY_OUT          = (r_state == StRun);
        STA_URUN_OUT     = r_urun;
        STA_URUN_CNT_OUT = r_urun_cnt;
        STA_STATE_OUT    = r_state;
    end

    for (genvar l = 0; l < P_LANES; l++) begin : g_lane
        for (genvar s = 0; s < P_SEGMENTS; s++) begin : g_seg
            assign FIFO_RD_OUT[l][s] = {P_STRIPES{w_rd}};
        end
    end

endmodule

// File: tb/tb_prt_dprx_vid_fifo_rdctl.sv
// Bench for prt_dprx_vid_fifo_rdctl: directed scenarios plus random traffic against a
// phase-level reference model and a simple FIFO occupancy model.
module tb_prt_dprx_vid_fifo_rdctl;

    localparam int unsigned NL  = 4;
    localparam int unsigned NS  = 4;
    localparam int unsigned NT  = 4;
    localparam int unsigned CLR = 4;
    localparam int unsigned NRD = NL * NS * NT;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLR   = 1;
    localparam int PH_PRIME = 2;
    localparam int PH_RUN   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_en;
    logic [5:0]     cfg_thres;
    logic [5:0]     fifo_lvl;
    logic           req;
    logic           sta_clr;
    logic           clr_out;
    logic [NT-1:0]  rd_out [NL][NS];
    logic           rdy;
    logic           urun_flag;
    logic [7:0]     urun_cnt;
    logic [1:0]     state;
    logic [NRD-1:0] rd_flat;

    int n_checks = 0;
    int n_errors = 0;
    int rd_seen  = 0;

    // Reference model: phase, remaining clear cycles, sticky flag, count.
    int m_phase    = PH_IDLE;
    int m_clr_left = 0;
    int m_flag     = 0;
    int m_cnt      = 0;
    int m_urun_evt = 0;

    prt_dprx_vid_fifo_rdctl #(
        .P_LANES   (NL),
        .P_SEGMENTS(NS),
        .P_STRIPES (NT),
        .P_CLR_CYC (CLR)
    ) dut (
        .VID_CLK_IN      (clk),
        .VID_RST_IN      (rst),
        .CFG_EN_IN       (cfg_en),
        .CFG_THRES_IN    (cfg_thres),
        .FIFO_LVL_IN     (fifo_lvl),
        .REQ_IN          (req),
        .STA_CLR_IN      (sta_clr),
        .FIFO_CLR_OUT    (clr_out),
        .FIFO_RD_OUT     (rd_out),
        .RDY_OUT         (rdy),
        .STA_URUN_OUT    (urun_flag),
        .STA_URUN_CNT_OUT(urun_cnt),
        .STA_STATE_OUT   (state)
    );

    always #5 clk = ~clk;

    always_comb begin
        rd_flat = '0;
        for (int l = 0; l < NL; l++) begin
            for (int s = 0; s < NS; s++) begin
                rd_flat[(l * NS + s) * NT +: NT] = rd_out[l][s];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = PH_IDLE;
        m_clr_left = 0;
        m_flag     = 0;
        m_cnt      = 0;
    endtask

    task automatic model_step(input int en, input int thres, input int lvl, input int rq,
                              input int sc);
        int need;
        int urun;
        urun = (m_phase == PH_RUN && rq != 0 && lvl == 0) ? 1 : 0;
        if (urun != 0) m_urun_evt++;
        if (sc != 0) begin
            m_flag = 0;
            m_cnt  = 0;
        end else if (urun != 0) begin
            m_flag = 1;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        need = (thres == 0) ? 1 : thres;
        if (en == 0) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_IDLE) begin
            m_phase    = PH_CLR;
            m_clr_left = CLR;
        end else if (m_phase == PH_CLR) begin
            m_clr_left--;
            if (m_clr_left == 0) m_phase = PH_PRIME;
        end else if (m_phase == PH_PRIME) begin
            if (lvl >= need) m_phase = PH_RUN;
        end else if (urun != 0) begin
            m_phase    = PH_CLR;
            m_clr_left = CLR;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input int en, input int thres, input int lvl, input int rq, input int sc);
        logic [NRD-1:0] exp_rd;
        cfg_en    = (en != 0);
        cfg_thres = 6'(thres);
        fifo_lvl  = 6'(lvl);
        req       = (rq != 0);
        sta_clr   = (sc != 0);
        #2;
        exp_rd = (m_phase == PH_RUN && rq != 0 && lvl != 0) ? '1 : '0;
        check_eq("state", 64'(state), 64'(m_phase));
        check_eq("fifo_clr", 64'(clr_out), 64'(m_phase == PH_IDLE || m_phase == PH_CLR));
        check_eq("rdy", 64'(rdy), 64'(m_phase == PH_RUN));
        check_eq("rd", 64'(rd_flat), 64'(exp_rd));
        check_eq("urun_flag", 64'(urun_flag), 64'(m_flag));
        check_eq("urun_cnt", 64'(urun_cnt), 64'(m_cnt));
        if (rd_flat[0]) rd_seen++;
        model_step(en, thres, lvl, rq, sc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int clr_w;
        int rd0;
        int lvl_sim;
        int thres_r;
        int ev0;

        rst = 1'b1; cfg_en = 1'b0; cfg_thres = 6'd8; fifo_lvl = 6'd0;
        req = 1'b0; sta_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_clr", 64'(clr_out), 64'd1);
        check_eq("rst_rdy", 64'(rdy), 64'd0);
        check_eq("rst_rd", 64'(rd_flat), 64'd0);
        check_eq("rst_flag", 64'(urun_flag), 64'd0);
        check_eq("rst_cnt", 64'(urun_cnt), 64'd0);
        rst = 1'b0;
        model_reset();

        // Bring-up: clear width, prime, run one cycle after threshold.
        cycle(0, 8, 0, 0, 0);
        cycle(1, 8, 0, 0, 0);
        clr_w = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 2'd1) break;
            clr_w += int'(clr_out);
            cycle(1, 8, 0, 0, 0);
        end
        check_eq("clr_width", 64'(clr_w), 64'(CLR));
        cycle(1, 8, 5, 0, 0);
        cycle(1, 8, 7, 0, 0);
        cycle(1, 8, 8, 0, 0);
        check_eq("run_after_thres", 64'(state), 64'd3);
        check_eq("rdy_after_thres", 64'(rdy), 64'd1);

        // Streaming: ten requests with plenty of data.
        rd0 = rd_seen;
        for (int i = 0; i < 10; i++) cycle(1, 8, 20 - i, 1, 0);
        check_eq("stream_reads", 64'(rd_seen - rd0), 64'd10);
        check_eq("stream_no_urun", 64'(urun_flag), 64'd0);

        // Underrun: one block, two requests.
        cycle(1, 8, 10, 0, 1);
        rd0 = rd_seen;
        cycle(1, 8, 1, 1, 0);
        cycle(1, 8, 0, 1, 0);
        check_eq("urun_reads", 64'(rd_seen - rd0), 64'd1);
        check_eq("urun_state", 64'(state), 64'd1);
        check_eq("urun_flag_set", 64'(urun_flag), 64'd1);
        check_eq("urun_cnt_one", 64'(urun_cnt), 64'd1);

        // Threshold 0 acts as 1.
        for (int i = 0; i < int'(CLR); i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        check_eq("thres0_hold", 64'(state), 64'd2);
        cycle(1, 0, 1, 0, 0);
        check_eq("thres0_run", 64'(state), 64'd3);

        // Disable mid-run.
        cycle(0, 0, 5, 1, 0);
        check_eq("dis_idle", 64'(state), 64'd0);
        cycle(0, 0, 5, 1, 0);

        // Asynchronous reset mid-run with the flag set.
        for (int i = 0; i < 20 && m_phase != PH_RUN; i++) cycle(1, 0, 1, 0, 0);
        check_eq("pre_rst_run", 64'(state), 64'd3);
        cfg_en = 1'b1; fifo_lvl = 6'd5; req = 1'b1; sta_clr = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("arst_state", 64'(state), 64'd0);
        check_eq("arst_clr", 64'(clr_out), 64'd1);
        check_eq("arst_rdy", 64'(rdy), 64'd0);
        check_eq("arst_rd", 64'(rd_flat), 64'd0);
        check_eq("arst_flag", 64'(urun_flag), 64'd0);
        check_eq("arst_cnt", 64'(urun_cnt), 64'd0);
        cfg_en = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Saturation: 300 underruns.
        ev0 = m_urun_evt;
        for (int i = 0; i < 4000 && (m_urun_evt - ev0) < 300; i++) begin
            cycle(1, 1, (m_phase == PH_RUN) ? 0 : 1, 1, 0);
        end
        check_eq("sat_budget", 64'(m_urun_evt - ev0), 64'd300);
        check_eq("sat_cnt", 64'(urun_cnt), 64'd255);
        for (int i = 0; i < 20 && m_phase != PH_RUN; i++) cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 1, 1);
        check_eq("clr_wins_cnt", 64'(urun_cnt), 64'd0);
        check_eq("clr_wins_flag", 64'(urun_flag), 64'd0);
        check_eq("clr_wins_state", 64'(state), 64'd1);

        // Random traffic against a FIFO occupancy model.
        lvl_sim = 0;
        thres_r = 4;
        for (int i = 0; i < 3000; i++) begin
            int en_r, rq_r, sc_r, rd_now, clr_now, wr;
            en_r = ($urandom_range(0, 99) != 0) ? 1 : 0;
            if ($urandom_range(0, 49) == 0) thres_r = int'($urandom_range(0, 12));
            rq_r = ($urandom_range(0, 9) < 8) ? 1 : 0;
            sc_r = ($urandom_range(0, 39) == 0) ? 1 : 0;
            rd_now  = (m_phase == PH_RUN && rq_r != 0 && lvl_sim != 0) ? 1 : 0;
            clr_now = (m_phase == PH_IDLE || m_phase == PH_CLR) ? 1 : 0;
            cycle(en_r, thres_r, lvl_sim, rq_r, sc_r);
            wr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if (clr_now != 0) lvl_sim = 0;
            else lvl_sim = lvl_sim - rd_now + wr;
            if (lvl_sim > 63) lvl_sim = 63;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
